// File: rtl/mask_readback.sv
// mask_readback: snapshots one of several live byte masks and streams its
// bytes out, lowest index first, over a valid/ready byte channel.
module mask_readback #(
    parameter int MASK_BYTES = 8,
    parameter int NUM_MASKS  = 5
) (
    input  logic                    in_clk,
    input  logic                    in_rst,
    input  logic                    in_req,
    input  logic [7:0]              in_P0,
    input  logic [7:0]              in_P1,
    input  logic [8*MASK_BYTES-1:0] in_mask_0,
    input  logic [8*MASK_BYTES-1:0] in_mask_1,
    input  logic [8*MASK_BYTES-1:0] in_mask_2,
    input  logic [8*MASK_BYTES-1:0] in_mask_3,
    input  logic [8*MASK_BYTES-1:0] in_mask_4,
    input  logic                    in_ready,
    output logic [7:0]              out_byte,
    output logic                    out_valid,
    output logic                    out_busy,
    output logic                    out_done,
    output logic                    out_err
);

    localparam int SW = 8 * MASK_BYTES;
    localparam int CW = $clog2(MASK_BYTES + 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state;
    logic [SW-1:0] snap;
    logic [SW-1:0] sel;
    logic [CW-1:0] cnt;
    logic          req_ok;

    // Pick the requested mask and decide whether the request is in range.
    always_comb begin
        sel = '0;
        case (in_P0)
            8'd0:    sel = in_mask_0;
            8'd1:    sel = in_mask_1;
            8'd2:    sel = in_mask_2;
            8'd3:    sel = in_mask_3;
            8'd4:    sel = in_mask_4;
            default: sel = '0;
        endcase
        req_ok = (in_P0 < 8'(NUM_MASKS)) && (in_P1 < 8'(MASK_BYTES));
    end

    // The current byte is always the bottom of the snapshot; it only moves
    // on a handshake, so it is stable while the consumer stalls.
    assign out_byte  = snap[7:0];
    assign out_valid = (state == SEND);
    assign out_busy  = (state == SEND);

    // Control FSM: accept/reject in IDLE, shift one byte per handshake in SEND.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state    <= IDLE;
            snap     <= '0;
            cnt      <= '0;
            out_done <= 1'b0;
            out_err  <= 1'b0;
        end else begin
            out_done <= 1'b0;
            out_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_req) begin
                        if (req_ok) begin
                            // Pre-shift so the first requested byte sits at [7:0].
                            snap  <= sel >> {in_P1, 3'b000};
                            cnt   <= CW'(MASK_BYTES) - CW'(in_P1);
                            state <= SEND;
                        end else begin
                            out_err <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (in_ready && cnt != '0) begin
                        snap <= snap >> 8;
                        cnt  <= cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                            state    <= IDLE;
                            out_done <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mask_readback.sv
// Scoreboard bench for mask_readback: stimulus pushes expected events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_mask_readback;

    logic        in_clk = 1'b0;
    logic        in_rst;
    logic        in_req;
    logic [7:0]  in_P0, in_P1;
    logic [63:0] in_mask_0, in_mask_1, in_mask_2, in_mask_3, in_mask_4;
    logic        in_ready;
    logic [7:0]  out_byte;
    logic        out_valid, out_busy, out_done, out_err;

    int total  = 0;
    int passed = 0;

    typedef struct {
        int         kind;   // 0 byte, 1 done, 2 err
        logic [7:0] data;
    } ev_t;
    ev_t exp_q[$];

    mask_readback dut (
        .in_clk(in_clk), .in_rst(in_rst), .in_req(in_req),
        .in_P0(in_P0), .in_P1(in_P1),
        .in_mask_0(in_mask_0), .in_mask_1(in_mask_1), .in_mask_2(in_mask_2),
        .in_mask_3(in_mask_3), .in_mask_4(in_mask_4),
        .in_ready(in_ready), .out_byte(out_byte), .out_valid(out_valid),
        .out_busy(out_busy), .out_done(out_done), .out_err(out_err)
    );

    always #5 in_clk = ~in_clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic int front_kind();
        return (exp_q.size() > 0) ? exp_q[0].kind : 99;
    endfunction

    // Monitor: compare every presented byte against the queue head, pop on
    // handshake, and match done/err pulses against expected events.
    always @(negedge in_clk) begin
        if (!in_rst) begin
            if (out_valid) begin
                if (front_kind() == 0) chk("byte", out_byte, exp_q[0].data);
                if (in_ready) begin
                    chk("hs_expected", front_kind(), 0);
                    if (front_kind() == 0) void'(exp_q.pop_front());
                end
            end
            if (out_done) begin
                chk("done_expected", front_kind(), 1);
                if (front_kind() == 1) void'(exp_q.pop_front());
            end
            if (out_err) begin
                chk("err_expected", front_kind(), 2);
                if (front_kind() == 2) void'(exp_q.pop_front());
            end
        end
    end

    // Issue a valid request (caller sits just after a posedge); expect nb bytes,
    // plus a done event when nb covers the rest of the mask.
    task automatic req(input int p0, input int p1, input logic [63:0] mask, input int nb);
        for (int k = p1; k < p1 + nb; k++) exp_q.push_back('{0, mask[8*k +: 8]});
        if (p1 + nb == 8) exp_q.push_back('{1, 8'h00});
        in_P0 = 8'(p0); in_P1 = 8'(p1); in_req = 1'b1;
        @(posedge in_clk); #1;
        in_req = 1'b0;
        chk("lat_valid", out_valid, 1'b1);
        chk("lat_busy", out_busy, 1'b1);
        chk("lat_first", out_byte, mask[8*p1 +: 8]);
    endtask

    task automatic req_bad(input int p0, input int p1);
        exp_q.push_back('{2, 8'h00});
        in_P0 = 8'(p0); in_P1 = 8'(p1); in_req = 1'b1;
        @(posedge in_clk); #1;
        in_req = 1'b0;
        chk("rej_err", out_err, 1'b1);
        chk("rej_valid", out_valid, 1'b0);
        chk("rej_busy", out_busy, 1'b0);
        @(posedge in_clk); #1;
        chk("rej_err_clr", out_err, 1'b0);
        chk("rej_busy2", out_busy, 1'b0);
    endtask

    // Bounded wait until out_done is seen (sampled just after a posedge).
    task automatic wait_done(input int limit);
        int n = 0;
        while (!out_done && n < limit) begin
            @(posedge in_clk); #1;
            n++;
        end
        chk("done_seen", out_done, 1'b1);
        chk("done_busy", out_busy, 1'b0);
    endtask

    initial begin
        logic [3:0] pat;
        pat = 4'b1001;  // ready pattern 1,0,0,1 (bit 3 first)
        in_rst = 1'b1; in_req = 1'b0; in_P0 = 8'd0; in_P1 = 8'd0; in_ready = 1'b1;
        in_mask_0 = 64'h0706050403020100;
        in_mask_1 = 64'h8192A3B4C5D6E7F8;
        in_mask_2 = 64'h8877665544332211;
        in_mask_3 = 64'hFFEEDDCCBBAA9988;
        in_mask_4 = 64'h0;
        repeat (2) @(posedge in_clk);
        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_busy", out_busy, 1'b0);
        chk("rst_done", out_done, 1'b0);
        chk("rst_err", out_err, 1'b0);
        chk("rst_byte", out_byte, 8'h00);
        in_rst = 1'b0;
        @(posedge in_clk); #1;

        // Full read, then a back-to-back partial read launched in the done cycle.
        req(0, 0, in_mask_0, 8);
        wait_done(20);
        req(3, 5, in_mask_3, 3);
        wait_done(20);
        @(posedge in_clk); #1;

        // Out-of-range requests.
        req_bad(5, 0);
        req_bad(0, 8);

        // Backpressure with the live mask cleared after the snapshot.
        req(1, 0, 64'h8192A3B4C5D6E7F8, 8);
        in_mask_1 = 64'h0;
        for (int i = 0; i < 100 && out_busy; i++) begin
            in_ready = pat[3 - (i % 4)];
            @(posedge in_clk); #1;
        end
        in_ready = 1'b1;
        chk("bp_idle", out_busy, 1'b0);
        @(posedge in_clk); #1;

        // Reset after three handshakes, then a fresh request restarts.
        req(2, 1, in_mask_2, 3);
        repeat (3) @(posedge in_clk);
        #1;
        in_rst = 1'b1; in_ready = 1'b0;
        @(posedge in_clk); #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_busy", out_busy, 1'b0);
        chk("mid_rst_byte", out_byte, 8'h00);
        chk("mid_rst_done", out_done, 1'b0);
        in_rst = 1'b0; in_ready = 1'b1;
        @(posedge in_clk); #1;
        chk("post_rst_done", out_done, 1'b0);
        req(2, 1, in_mask_2, 7);
        wait_done(20);
        @(posedge in_clk); #1;
        @(posedge in_clk); #1;

        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
